// File: rtl/wb_stream_fifo.sv
// wb_stream_fifo
//   Wishbone-writable sample FIFO that drains over a valid/ready stream into
//   the waveform generator core.
//
//   Optional feature macro: WB_STREAM_FIFO_IRQ_EN
//     Defined   : adds the irq_low output and the THRESH register (adr 4).
//     Undefined : no irq_low port; adr 4 reads 0 and ignores writes.
//
// Ports
//   io_wbs_clk       clock
//   io_wbs_rst       synchronous active-high reset
//   io_wbs_adr       byte address, only [4:2] decoded
//   io_wbs_datwr     write data
//   io_wbs_datrd     read data (valid while io_wbs_ack=1)
//   io_wbs_we        write enable
//   io_wbs_sel       byte select (ignored, all accesses are full-word)
//   io_wbs_stb       strobe
//   io_wbs_ack       acknowledge (one cycle per request)
//   io_wbs_cyc       cycle
//   wfg_axis_tdata   stream data = FIFO head (first-word-fall-through)
//   wfg_axis_tvalid  stream valid
//   wfg_axis_tready  stream ready
//   irq_low          FIFO level at or below THRESH (macro builds only)
//
// Register map (adr[4:2])
//   0 CTRL   bit0 enable, bit1 flush (write-1 pulse, reads 0)
//   1 STATUS bit0 empty, bit1 full, bit2 overflow (sticky, W1C)
//   2 DATA   write pushes a sample, reads 0
//   3 LEVEL  fill count
//   4 THRESH low-level threshold (macro builds only)

module wb_stream_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        io_wbs_clk,
  input  logic        io_wbs_rst,
  input  logic [31:0] io_wbs_adr,
  input  logic [31:0] io_wbs_datwr,
  output logic [31:0] io_wbs_datrd,
  input  logic        io_wbs_we,
  input  logic [3:0]  io_wbs_sel,
  input  logic        io_wbs_stb,
  output logic        io_wbs_ack,
  input  logic        io_wbs_cyc,
  output logic [31:0] wfg_axis_tdata,
  output logic        wfg_axis_tvalid,
  input  logic        wfg_axis_tready
`ifdef WB_STREAM_FIFO_IRQ_EN
  ,
  output logic        irq_low
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          enable, enable_nxt;
  logic          overflow;

  logic          req, wr, rd;
  logic [2:0]    reg_sel;
  logic          ctrl_wr, status_wr, data_wr;
  logic          flush, pop, full, empty, push, push_drop;
  logic [31:0]   rdata;

  // Byte lanes and the undecoded address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = &{1'b0, io_wbs_sel, io_wbs_adr[31:5], io_wbs_adr[1:0]};

  // The ack term keeps a held strobe from being seen as a second request.
  assign req     = io_wbs_stb & io_wbs_cyc & ~io_wbs_ack;
  assign wr      = req & io_wbs_we;
  assign rd      = req & ~io_wbs_we;
  assign reg_sel = io_wbs_adr[4:2];

  assign ctrl_wr   = wr & (reg_sel == 3'd0);
  assign status_wr = wr & (reg_sel == 3'd1);
  assign data_wr   = wr & (reg_sel == 3'd2);
  assign flush     = ctrl_wr & io_wbs_datwr[1];

  assign empty     = (count == '0);
  assign full      = (count == CW'(FIFO_DEPTH));

  assign wfg_axis_tvalid = enable & ~empty;
  assign wfg_axis_tdata  = mem[rd_ptr];
  assign pop             = wfg_axis_tvalid & wfg_axis_tready;

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign push      = data_wr & (~full | pop);
  assign push_drop = data_wr & full & ~pop;

  assign enable_nxt = ctrl_wr ? io_wbs_datwr[0] : enable;

  always_comb begin
    count_nxt  = count;
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    if (flush) begin
      count_nxt  = '0;
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
    end else begin
      if (push) wr_ptr_nxt = wr_ptr + AW'(1);
      if (pop)  rd_ptr_nxt = rd_ptr + AW'(1);
      if (push && !pop)      count_nxt = count + CW'(1);
      else if (pop && !push) count_nxt = count - CW'(1);
    end
  end

`ifdef WB_STREAM_FIFO_IRQ_EN
  logic [CW-1:0] thresh, thresh_nxt;
  logic          thresh_wr;

  assign thresh_wr  = wr & (reg_sel == 3'd4);
  assign thresh_nxt = thresh_wr ? io_wbs_datwr[CW-1:0] : thresh;

  always_ff @(posedge io_wbs_clk) begin
    if (io_wbs_rst) begin
      thresh  <= '0;
      irq_low <= 1'b0;
    end else begin
      thresh  <= thresh_nxt;
      // Compare against the post-update level so the flag tracks LEVEL exactly.
      irq_low <= enable_nxt & (count_nxt <= thresh_nxt);
    end
  end
`endif

  always_comb begin
    rdata = '0;
    case (reg_sel)
      3'd0:    rdata = {31'd0, enable};
      3'd1:    rdata = {29'd0, overflow, full, empty};
      3'd3:    rdata = {{(32-CW){1'b0}}, count};
`ifdef WB_STREAM_FIFO_IRQ_EN
      3'd4:    rdata = {{(32-CW){1'b0}}, thresh};
`endif
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge io_wbs_clk) begin
    if (io_wbs_rst) begin
      io_wbs_ack   <= 1'b0;
      io_wbs_datrd <= '0;
      enable       <= 1'b0;
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      overflow     <= 1'b0;
    end else begin
      io_wbs_ack   <= req;
      io_wbs_datrd <= rd ? rdata : 32'd0;
      enable       <= enable_nxt;
      count        <= count_nxt;
      rd_ptr       <= rd_ptr_nxt;
      wr_ptr       <= wr_ptr_nxt;
      // A drop on the same cycle as a clear leaves the flag set.
      if (push_drop)
        overflow <= 1'b1;
      else if (status_wr && io_wbs_datwr[2])
        overflow <= 1'b0;
    end
  end

  // Sample storage has no reset; validity is tracked by count alone.
  always_ff @(posedge io_wbs_clk) begin
    if (push)
      mem[wr_ptr] <= io_wbs_datwr;
  end

endmodule

// File: tb/tb_wb_stream_fifo.sv
module tb_wb_stream_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] datwr = '0;
  logic [31:0] datrd;
  logic        we = 1'b0;
  logic [3:0]  sel = '0;
  logic        stb = 1'b0;
  logic        ack;
  logic        cyc = 1'b0;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready = 1'b0;
`ifdef WB_STREAM_FIFO_IRQ_EN
  logic        irq_low;
`endif

  wb_stream_fifo #(.FIFO_DEPTH(DEPTH)) dut (
    .io_wbs_clk      (clk),
    .io_wbs_rst      (rst),
    .io_wbs_adr      (adr),
    .io_wbs_datwr    (datwr),
    .io_wbs_datrd    (datrd),
    .io_wbs_we       (we),
    .io_wbs_sel      (sel),
    .io_wbs_stb      (stb),
    .io_wbs_ack      (ack),
    .io_wbs_cyc      (cyc),
    .wfg_axis_tdata  (tdata),
    .wfg_axis_tvalid (tvalid),
    .wfg_axis_tready (tready)
`ifdef WB_STREAM_FIFO_IRQ_EN
    ,
    .irq_low         (irq_low)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t     exp_rd[$];
  logic [31:0] exp_stream[$];

  // Reference model: a plain queue plus a few flags.
  logic [31:0] m_q[$];
  bit          m_en, m_ovf, m_ack, m_irq, m_live;
  int          m_thresh;
  bit          rand_ready = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  always @(posedge clk) begin : model
    bit          req, pop, flush, drop;
    int          pre;
    logic [2:0]  a;
    logic [31:0] rv;
    m_live = 1;
    if (rst) begin
      m_en = 0; m_ovf = 0; m_ack = 0; m_irq = 0; m_thresh = 0;
      m_q.delete(); exp_stream.delete(); exp_rd.delete();
    end else begin
      req   = stb && cyc && !m_ack;
      a     = adr[4:2];
      pre   = m_q.size();
      pop   = m_en && pre != 0 && tready;
      flush = 0;
      drop  = 0;
      if (req) begin
        rv = 0;
        if (a == 3'd0) rv = {31'd0, m_en};
        if (a == 3'd1) rv = {29'd0, m_ovf, pre == DEPTH, pre == 0};
        if (a == 3'd3) rv = pre;
`ifdef WB_STREAM_FIFO_IRQ_EN
        if (a == 3'd4) rv = m_thresh;
`endif
        exp_rd.push_back('{!we, rv});
        if (we && a == 3'd0) flush = datwr[1];
      end
      if (flush) begin
        m_q.delete();
        exp_stream.delete();
      end else begin
        if (pop) void'(m_q.pop_front());
        if (req && we && a == 3'd2) begin
          if (pre < DEPTH || pop) begin
            m_q.push_back(datwr);
            exp_stream.push_back(datwr);
          end else drop = 1;
        end
      end
      if (req && we && a == 3'd1 && datwr[2]) m_ovf = 0;
      if (drop) m_ovf = 1;
      if (req && we && a == 3'd0) m_en = datwr[0];
`ifdef WB_STREAM_FIFO_IRQ_EN
      if (req && we && a == 3'd4) m_thresh = int'(datwr[4:0]);
`endif
      m_irq = m_en && (m_q.size() <= m_thresh);
      m_ack = req;
    end
  end

  always @(negedge clk) begin : monitor
    rd_exp_t e;
    if (m_live) begin
      chk("ack", {31'd0, ack}, {31'd0, m_ack});
      if (ack) begin
        if (exp_rd.size() == 0) fail_now("ack_without_request");
        else begin
          e = exp_rd.pop_front();
          if (e.is_rd) chk("datrd", datrd, e.data);
        end
      end
      chk("tvalid", {31'd0, tvalid}, {31'd0, (m_en && m_q.size() != 0)});
      if (tvalid && tready) begin
        if (exp_stream.size() == 0) fail_now("tdata_unexpected_beat");
        else chk("tdata", tdata, exp_stream.pop_front());
      end
`ifdef WB_STREAM_FIFO_IRQ_EN
      chk("irq_low", {31'd0, irq_low}, {31'd0, m_irq});
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) tready = 1'($urandom_range(0, 1));
  endtask

  task automatic wb(input bit w, input logic [2:0] r, input logic [31:0] d, input bit rdy_pulse = 0);
    int n;
    logic [31:0] hi;
    hi    = $urandom() & 32'hFFFF_FFE0;
    adr   = hi | {27'd0, r, 2'b00};
    we    = w;
    datwr = d;
    sel   = 4'($urandom_range(0, 15));
    stb   = 1'b1;
    cyc   = 1'b1;
    if (rdy_pulse) tready = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (rdy_pulse) tready = 1'b0;
    end while (!ack && n < 8);
    if (!ack) fail_now("ack_timeout");
    stb = 1'b0;
    cyc = 1'($urandom_range(0, 1));
    we  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          op;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state reads
    wb(0, 3'd1, 0);
    wb(0, 3'd3, 0);
    wb(0, 3'd0, 0);

    // Fill while disabled, then enable and stream
    for (int i = 1; i <= 3; i++) wb(1, 3'd2, 32'hA5A5_0000 + i);
    tready = 1'b1;
    wb(1, 3'd0, 32'd1);
    repeat (4) tick();
    wb(0, 3'd3, 0);

    // Overflow: 17 pushes into 16 entries, then clear
    tready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) wb(1, 3'd2, $urandom());
    wb(0, 3'd3, 0);
    wb(0, 3'd1, 0);
    wb(1, 3'd1, 32'h4);
    wb(0, 3'd1, 0);
    tready = 1'b1;
    repeat (DEPTH + 4) tick();
    tready = 1'b0;

    // Push into a full FIFO on a pop cycle
    for (int i = 0; i < DEPTH; i++) wb(1, 3'd2, $urandom());
    wb(1, 3'd2, 32'hDEAD_BEEF, 1);
    wb(0, 3'd3, 0);
    wb(0, 3'd1, 0);
    tready = 1'b1;
    repeat (DEPTH + 4) tick();
    tready = 1'b0;

    // Flush with enable kept
    for (int i = 0; i < 5; i++) wb(1, 3'd2, $urandom());
    wb(1, 3'd0, 32'h3);
    wb(0, 3'd3, 0);
    wb(0, 3'd0, 0);
    tick();

    // Threshold / register 4
`ifdef WB_STREAM_FIFO_IRQ_EN
    wb(1, 3'd4, 32'd2);
    for (int i = 0; i < 4; i++) wb(1, 3'd2, $urandom());
    tready = 1'b1;
    repeat (6) tick();
    tready = 1'b0;
`else
    wb(1, 3'd4, 32'hFFFF_FFFF);
`endif
    wb(0, 3'd4, 0);

    // Randomized traffic
    rand_ready = 1;
    for (int it = 0; it < 600; it++) begin
      if (it == 300) begin
        adr = 32'h0000_000C; we = 1'b0; stb = 1'b1; cyc = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; stb = 1'b0;
        tick();
        wb(1, 3'd0, 32'd1);
      end
      op = $urandom_range(0, 11);
      d  = $urandom();
      if (op <= 4) wb(1, 3'd2, d);
      else if (op == 5) begin
        d[0] = ($urandom_range(0, 3) != 0);
        d[1] = ($urandom_range(0, 7) == 0);
        wb(1, 3'd0, d);
      end
      else if (op == 6) wb(1, 3'd1, d);
      else if (op <= 8) wb(0, 3'($urandom_range(0, 7)), d);
      else if (op == 9) wb(1, 3'd4, 32'($urandom_range(0, 17)));
      else repeat ($urandom_range(1, 4)) tick();
    end

    rand_ready = 0;
    tready = 1'b1;
    wb(1, 3'd0, 32'd1);
    repeat (DEPTH + 8) tick();
    chk("pending_reads", 32'(exp_rd.size()), 32'd0);
    chk("stream_left", 32'(exp_stream.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
